// File: rtl/fe_fetch_pkg.sv
// Shared front-end definitions: default sizes, reset PC and the fetch-queue entry layout.
package fe_fetch_pkg;

    localparam int FE_WORD_SIZE = 16;
    localparam int FE_DEPTH     = 4;
    localparam logic [FE_WORD_SIZE-1:0] FE_RESET_PC = 16'h0000;

    typedef struct packed {
        logic [FE_WORD_SIZE-1:0] pc;
        logic [FE_WORD_SIZE-1:0] instr;
    } fe_fetch_entry_s;

endpackage

// File: rtl/fe_fifo.sv
// Synchronous pointer-based FIFO with flush; occupancy is tracked by the owner, so no full/empty flags.
module fe_fifo #(
    parameter int WIDTH_P = 32,
    parameter int DEPTH_P = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               flush_i,
    input  logic               push_i,
    input  logic [WIDTH_P-1:0] data_i,
    input  logic               pop_i,
    output logic [WIDTH_P-1:0] data_o
);

    localparam int AW = $clog2(DEPTH_P);

    logic [WIDTH_P-1:0] r_mem [DEPTH_P];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push_i) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop_i)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) r_mem[r_wr_ptr] <= data_i;
    end

    // Head is read combinationally so the consumer sees it in the cycle after the write.
    assign data_o = r_mem[r_rd_ptr];

endmodule

// File: rtl/fe_fetch.sv
// Instruction fetch stage: PC, credit-limited word fetch, in-order instruction queue, redirect flush.
module fe_fetch
    import fe_fetch_pkg::*;
#(
    parameter int                     WORD_SIZE_P = FE_WORD_SIZE,
    parameter int                     DEPTH_P     = FE_DEPTH,
    parameter logic [WORD_SIZE_P-1:0] RESET_PC_P  = FE_RESET_PC
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    output logic                   imem_v_o,
    output logic [WORD_SIZE_P-1:0] imem_addr_o,
    input  logic                   imem_ready_i,
    input  logic                   imem_data_v_i,
    input  logic [WORD_SIZE_P-1:0] imem_data_i,
    input  logic                   redirect_v_i,
    input  logic [WORD_SIZE_P-1:0] redirect_pc_i,
    output logic                   instr_v_o,
    output logic [WORD_SIZE_P-1:0] instr_o,
    output logic [WORD_SIZE_P-1:0] instr_pc_o,
    input  logic                   instr_ready_i
);

    localparam int            CW      = $clog2(DEPTH_P) + 1;
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH_P);

    logic [WORD_SIZE_P-1:0]   r_pc;
    logic [CW-1:0]            r_count;
    logic [CW-1:0]            r_out;
    logic [CW-1:0]            r_drop;

    logic                     w_credit;
    logic                     w_accept;
    logic                     w_resp_keep;
    logic                     w_resp_drop;
    logic                     w_deq;
    logic [WORD_SIZE_P-1:0]   w_tag;
    logic [2*WORD_SIZE_P-1:0] w_head;

    // Queued plus kept-in-flight may never exceed the queue size, so the queue cannot overflow.
    assign w_credit    = ({1'b0, r_count} + {1'b0, r_out}) < DEPTH_C;
    assign imem_v_o    = reset_n_i && !redirect_v_i && w_credit;
    assign imem_addr_o = r_pc;
    assign w_accept    = imem_v_o && imem_ready_i;

    assign w_resp_drop = imem_data_v_i && (r_drop != '0);
    assign w_resp_keep = imem_data_v_i && (r_drop == '0) && !redirect_v_i;

    assign instr_v_o   = (r_count != '0);
    assign w_deq       = instr_v_o && instr_ready_i && !redirect_v_i;
    assign instr_o     = instr_v_o ? w_head[WORD_SIZE_P-1:0]             : '0;
    assign instr_pc_o  = instr_v_o ? w_head[2*WORD_SIZE_P-1:WORD_SIZE_P] : '0;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_pc    <= RESET_PC_P;
            r_count <= '0;
            r_out   <= '0;
            r_drop  <= '0;
        end else if (redirect_v_i) begin
            // Every unreturned request becomes a drop, less the response consumed right now.
            r_pc    <= redirect_pc_i;
            r_count <= '0;
            r_out   <= '0;
            r_drop  <= r_drop + r_out - CW'(imem_data_v_i);
        end else begin
            if (w_accept) r_pc <= r_pc + 1'b1;
            r_count <= r_count + CW'(w_resp_keep) - CW'(w_deq);
            r_out   <= r_out + CW'(w_accept) - CW'(w_resp_keep);
            r_drop  <= r_drop - CW'(w_resp_drop);
        end
    end

    fe_fifo #(
        .WIDTH_P (WORD_SIZE_P),
        .DEPTH_P (DEPTH_P)
    ) u_tag_q (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .flush_i   (redirect_v_i),
        .push_i    (w_accept),
        .data_i    (r_pc),
        .pop_i     (w_resp_keep),
        .data_o    (w_tag)
    );

    fe_fifo #(
        .WIDTH_P (2*WORD_SIZE_P),
        .DEPTH_P (DEPTH_P)
    ) u_instr_q (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .flush_i   (redirect_v_i),
        .push_i    (w_resp_keep),
        .data_i    ({w_tag, imem_data_i}),
        .pop_i     (w_deq),
        .data_o    (w_head)
    );

endmodule

// File: tb/tb_fe_fetch.sv
// Scoreboard bench for fe_fetch: memory model feeds an expected queue, a monitor checks every dequeue.
`timescale 1ns/1ps
module tb_fe_fetch;
    import fe_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_v;
    logic [15:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_data_v = 1'b0;
    logic [15:0] imem_data = 16'h0;
    logic        redirect_v = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic        instr_v;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready = 1'b0;

    fe_fetch dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .imem_v_o      (imem_v),
        .imem_addr_o   (imem_addr),
        .imem_ready_i  (imem_ready),
        .imem_data_v_i (imem_data_v),
        .imem_data_i   (imem_data),
        .redirect_v_i  (redirect_v),
        .redirect_pc_i (redirect_pc),
        .instr_v_o     (instr_v),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .instr_ready_i (instr_ready)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } mreq_t;

    mreq_t           mq[$];
    fe_fetch_entry_s exp_q[$];

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          n_acc = 0;
    int          n_pop = 0;
    int          lat = 1;
    int          ready_mode = 0;   // 0: ready, 1: stalled, 2: random
    int          rdy_mode = 0;     // 0: decode ready, 1: held off, 2: random
    logic        redir_req = 1'b0;
    logic [15:0] redir_pc_req = 16'h0;

    function automatic logic [15:0] memfn(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC0DE;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic next();
        @(negedge clk);
        #2;
    endtask

    task automatic do_redirect(input logic [15:0] pc);
        redir_req = 1'b1;
        redir_pc_req = pc;
        next();
        redir_req = 1'b0;
        next();
        check("redir_instr_v", {31'b0, instr_v}, 32'd0);
        check("redir_imem_v", {31'b0, imem_v}, 32'd1);
        check("redir_addr", {16'b0, imem_addr}, {16'b0, pc});
    endtask

    task automatic wait_first(input logic [15:0] pc);
        int n;
        n = 0;
        while (!instr_v && n < 30) begin
            next();
            n++;
        end
        check("first_v", {31'b0, instr_v}, 32'd1);
        check("first_pc", {16'b0, instr_pc}, {16'b0, pc});
        check("first_instr", {16'b0, instr}, {16'b0, memfn(pc)});
    endtask

    // Driver and memory model: inputs change on the falling edge, the accept is recorded before the rising edge.
    initial begin
        mreq_t           m;
        fe_fetch_entry_s e;
        forever begin
            @(negedge clk);
            cyc++;
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                imem_data_v = 1'b1;
                imem_data   = memfn(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                imem_data_v = 1'b0;
                imem_data   = 16'($urandom);
            end
            case (ready_mode)
                0:       imem_ready = 1'b1;
                1:       imem_ready = 1'b0;
                default: imem_ready = 1'($urandom_range(0, 1));
            endcase
            case (rdy_mode)
                0:       instr_ready = 1'b1;
                1:       instr_ready = 1'b0;
                default: instr_ready = 1'($urandom_range(0, 1));
            endcase
            redirect_v  = redir_req;
            redirect_pc = redir_req ? redir_pc_req : 16'($urandom);
            #6;
            if (redirect_v) exp_q.delete();
            if (imem_v && imem_ready) begin
                m.addr = imem_addr;
                m.due  = cyc + lat;
                mq.push_back(m);
                e.pc    = imem_addr;
                e.instr = memfn(imem_addr);
                exp_q.push_back(e);
                n_acc++;
            end
        end
    end

    // Monitor: every consumed head must match the oldest surviving expected entry.
    initial begin
        fe_fetch_entry_s e;
        forever begin
            @(negedge clk);
            #4;
            if (reset_n && redirect_v)
                check("redir_no_issue", {31'b0, imem_v}, 32'd0);
            if (reset_n && instr_v && instr_ready && !redirect_v) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL deq_unexpected: got pc %h expected no entry (cycle %0d)", instr_pc, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("deq_pc", {16'b0, instr_pc}, {16'b0, e.pc});
                    check("deq_instr", {16'b0, instr}, {16'b0, e.instr});
                end
            end
        end
    end

    initial begin
        #200000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int n_pop0;
        repeat (3) next();
        check("rst_imem_v", {31'b0, imem_v}, 32'd0);
        check("rst_addr", {16'b0, imem_addr}, 32'h0000);
        check("rst_instr_v", {31'b0, instr_v}, 32'd0);
        check("rst_instr", {16'b0, instr}, 32'h0000);
        check("rst_pc", {16'b0, instr_pc}, 32'h0000);

        // Streaming after reset with single-cycle memory
        reset_n = 1'b1;
        #1;
        check("rel_imem_v", {31'b0, imem_v}, 32'd1);
        check("rel_addr", {16'b0, imem_addr}, 32'h0000);
        next();
        check("c1_addr", {16'b0, imem_addr}, 32'h0001);
        check("c1_instr_v", {31'b0, instr_v}, 32'd0);
        next();
        check("c2_v", {31'b0, instr_v}, 32'd1);
        check("c2_pc", {16'b0, instr_pc}, 32'h0000);
        check("c2_instr", {16'b0, instr}, {16'b0, memfn(16'h0000)});
        next();
        check("c3_pc", {16'b0, instr_pc}, 32'h0001);
        next();
        check("c4_pc", {16'b0, instr_pc}, 32'h0002);

        // Decode stalled: exactly four requests fill the queue
        rdy_mode = 1;
        do_redirect(16'h0100);
        n_acc = 0;
        repeat (10) next();
        check("fill_acc", n_acc, 32'd4);
        check("fill_imem_v", {31'b0, imem_v}, 32'd0);
        check("fill_head_pc", {16'b0, instr_pc}, 32'h0100);
        rdy_mode = 0;
        next();
        check("drain0_pc", {16'b0, instr_pc}, 32'h0100);
        check("drain0_imem_v", {31'b0, imem_v}, 32'd0);
        next();
        check("drain1_pc", {16'b0, instr_pc}, 32'h0101);
        check("drain1_imem_v", {31'b0, imem_v}, 32'd1);
        check("drain1_addr", {16'b0, imem_addr}, 32'h0104);
        repeat (6) next();

        // Redirect with two requests in flight at latency 3
        ready_mode = 1;
        do_redirect(16'h0200);
        ready_mode = 0;
        lat = 3;
        n_acc = 0;
        next();
        next();
        do_redirect(16'h0040);
        check("inflight_acc", n_acc, 32'd2);
        wait_first(16'h0040);

        // Redirect coinciding with a response and a dequeue
        lat = 1;
        repeat (8) next();
        redir_req = 1'b1;
        redir_pc_req = 16'h0300;
        next();
        redir_req = 1'b0;
        check("coinc_pre_v", {31'b0, instr_v}, 32'd1);
        next();
        check("coinc_instr_v", {31'b0, instr_v}, 32'd0);
        check("coinc_addr", {16'b0, imem_addr}, 32'h0300);
        wait_first(16'h0300);

        // PC wrap
        repeat (3) next();
        do_redirect(16'hFFFE);
        next();
        check("wrap_addr1", {16'b0, imem_addr}, 32'hFFFF);
        next();
        check("wrap_addr2", {16'b0, imem_addr}, 32'h0000);
        check("wrap_pc0", {16'b0, instr_pc}, 32'hFFFE);
        next();
        check("wrap_pc1", {16'b0, instr_pc}, 32'hFFFF);
        next();
        check("wrap_pc2", {16'b0, instr_pc}, 32'h0000);

        // Random ready and redirects
        lat = 2;
        ready_mode = 2;
        rdy_mode = 2;
        for (int i = 0; i < 1000; i++) begin
            next();
            redir_req = ($urandom_range(0, 24) == 0);
            redir_pc_req = 16'($urandom);
        end
        redir_req = 1'b0;
        ready_mode = 0;
        rdy_mode = 0;
        next();
        n_pop0 = n_pop;
        repeat (20) next();
        check("drain_progress", {31'b0, (n_pop - n_pop0) >= 15}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
